// File: rtl/fwd_hazard_ctrl.sv
// Hazard detection and operand forwarding for a parametrised post-decode
// pipeline. A small scoreboard shadows every in-flight instruction from EXE
// (stage 1) to WB (stage STAGES) and drives the decode stall, the EXE
// forwarding selects and the forwarded operand values.
module fwd_hazard_ctrl #(
    parameter int unsigned RA_W       = 4,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STAGES     = 3,
    parameter int unsigned LOAD_STAGE = 3,
    localparam int unsigned SEL_W     = $clog2(STAGES)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         fwd_en,
    input  logic                         hold,
    input  logic                         flush,
    input  logic                         id_valid,
    input  logic [RA_W-1:0]              id_src1,
    input  logic [RA_W-1:0]              id_src2,
    input  logic                         id_src1_vld,
    input  logic                         id_src2_vld,
    input  logic [RA_W-1:0]              id_dest,
    input  logic                         id_wb_en,
    input  logic                         id_mem_r_en,
    input  logic [DATA_W-1:0]            exe_rn,
    input  logic [DATA_W-1:0]            exe_rm,
    input  logic [(STAGES-1)*DATA_W-1:0] stage_res,
    output logic                         hazard,
    output logic [SEL_W-1:0]             sel1,
    output logic [SEL_W-1:0]             sel2,
    output logic [DATA_W-1:0]            op1,
    output logic [DATA_W-1:0]            op2,
    output logic                         exe_valid
);

    localparam int NS     = int'(STAGES);
    // Deepest stage whose load result is still too late to forward into EXE.
    localparam int LD_LIM = int'(LOAD_STAGE) - 2;

    typedef struct packed {
        logic            valid;
        logic            wb_en;
        logic            mem_r_en;
        logic [RA_W-1:0] dest;
        logic [RA_W-1:0] src1;
        logic            src1_vld;
        logic [RA_W-1:0] src2;
        logic            src2_vld;
    } sb_entry_t;

    sb_entry_t sb_q [1:STAGES];
    sb_entry_t sb_d [1:STAGES];

    logic hz_src1_c;
    logic hz_src2_c;

    function automatic logic match(input sb_entry_t e, input logic [RA_W-1:0] s);
        return e.valid && e.wb_en && (e.dest == s);
    endfunction

    // Decode-side hazard: stall-only mode waits for any producer short of WB,
    // forwarding mode only waits for loads whose data is not yet on a bus.
    always_comb begin
        hz_src1_c = 1'b0;
        hz_src2_c = 1'b0;
        for (int k = 1; k < NS; k++) begin
            if (!fwd_en) begin
                hz_src1_c |= match(sb_q[k], id_src1);
                hz_src2_c |= match(sb_q[k], id_src2);
            end else if (k <= LD_LIM) begin
                hz_src1_c |= match(sb_q[k], id_src1) && sb_q[k].mem_r_en;
                hz_src2_c |= match(sb_q[k], id_src2) && sb_q[k].mem_r_en;
            end
        end
        hazard = id_valid && ((id_src1_vld && hz_src1_c) || (id_src2_vld && hz_src2_c));
    end

    // Scoreboard advance: shift one stage unless frozen, insert decode or a bubble.
    always_comb begin
        sb_d = sb_q;
        if (!hold) begin
            for (int k = NS; k >= 2; k--) begin
                sb_d[k] = sb_q[k-1];
            end
            sb_d[1] = '0;
            if (id_valid && !hazard && !flush) begin
                sb_d[1].valid    = 1'b1;
                sb_d[1].wb_en    = id_wb_en;
                sb_d[1].mem_r_en = id_mem_r_en;
                sb_d[1].dest     = id_dest;
                sb_d[1].src1     = id_src1;
                sb_d[1].src1_vld = id_src1_vld;
                sb_d[1].src2     = id_src2;
                sb_d[1].src2_vld = id_src2_vld;
            end
        end
    end

    // Scoreboard state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 1; k <= NS; k++) begin
                sb_q[k] <= '0;
            end
        end else begin
            sb_q <= sb_d;
        end
    end

    // EXE forwarding: scan oldest to youngest so the youngest producer wins.
    always_comb begin
        sel1 = '0;
        sel2 = '0;
        if (fwd_en && sb_q[1].valid) begin
            for (int k = NS; k >= 2; k--) begin
                if (sb_q[1].src1_vld && match(sb_q[k], sb_q[1].src1)) begin
                    sel1 = SEL_W'(k - 1);
                end
                if (sb_q[1].src2_vld && match(sb_q[k], sb_q[1].src2)) begin
                    sel2 = SEL_W'(k - 1);
                end
            end
        end
        op1 = exe_rn;
        op2 = exe_rm;
        for (int k = 2; k <= NS; k++) begin
            if (sel1 == SEL_W'(k - 1)) begin
                op1 = stage_res[(k-2)*DATA_W +: DATA_W];
            end
            if (sel2 == SEL_W'(k - 1)) begin
                op2 = stage_res[(k-2)*DATA_W +: DATA_W];
            end
        end
    end

    assign exe_valid = sb_q[1].valid;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: default 3-stage instance plus a
// 5-stage instance with late load data.
`timescale 1ns/1ps
module tb_fwd_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        fwd_en, hold, flush;
    logic        id_valid, id_src1_vld, id_src2_vld, id_wb_en, id_mem_r_en;
    logic [3:0]  id_src1, id_src2, id_dest;
    logic [31:0] exe_rn, exe_rm;
    logic [63:0]  stage_res_a;
    logic [127:0] stage_res_b;

    logic        hazard_a, exe_valid_a;
    logic [1:0]  sel1_a, sel2_a;
    logic [31:0] op1_a, op2_a;
    logic        hazard_b, exe_valid_b;
    logic [2:0]  sel1_b, sel2_b;
    logic [31:0] op1_b, op2_b;

    int total = 0;
    int bad   = 0;

    fwd_hazard_ctrl #(.RA_W(4), .DATA_W(32), .STAGES(3), .LOAD_STAGE(3)) dut_a (
        .clk(clk), .rst(rst), .fwd_en(fwd_en), .hold(hold), .flush(flush),
        .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_src1_vld(id_src1_vld), .id_src2_vld(id_src2_vld), .id_dest(id_dest),
        .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .exe_rn(exe_rn), .exe_rm(exe_rm),
        .stage_res(stage_res_a), .hazard(hazard_a), .sel1(sel1_a), .sel2(sel2_a),
        .op1(op1_a), .op2(op2_a), .exe_valid(exe_valid_a)
    );

    fwd_hazard_ctrl #(.RA_W(4), .DATA_W(32), .STAGES(5), .LOAD_STAGE(4)) dut_b (
        .clk(clk), .rst(rst), .fwd_en(fwd_en), .hold(hold), .flush(flush),
        .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_src1_vld(id_src1_vld), .id_src2_vld(id_src2_vld), .id_dest(id_dest),
        .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .exe_rn(exe_rn), .exe_rm(exe_rm),
        .stage_res(stage_res_b), .hazard(hazard_b), .sel1(sel1_b), .sel2(sel2_b),
        .op1(op1_b), .op2(op2_b), .exe_valid(exe_valid_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        id_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic dec(input logic [3:0] s1, input logic v1, input logic [3:0] s2,
                       input logic v2, input logic [3:0] d, input logic wb, input logic mr);
        id_valid    = 1'b1;
        id_src1     = s1;
        id_src1_vld = v1;
        id_src2     = s2;
        id_src2_vld = v2;
        id_dest     = d;
        id_wb_en    = wb;
        id_mem_r_en = mr;
    endtask

    function automatic logic clash(input logic v1, input logic [3:0] s1, input logic s1v,
                                   input logic [3:0] s2, input logic s2v, input logic vk,
                                   input logic wk, input logic mk, input logic [3:0] dk);
        return v1 && vk && wk && mk && ((s1v && dk == s1) || (s2v && dk == s2));
    endfunction

    // A load in EXE's producer range but short of LOAD_STAGE must never meet its consumer.
    always @(negedge clk) begin
        if (rst) begin
            chk("ld_early_a2", clash(dut_a.sb_q[1].valid, dut_a.sb_q[1].src1, dut_a.sb_q[1].src1_vld,
                dut_a.sb_q[1].src2, dut_a.sb_q[1].src2_vld, dut_a.sb_q[2].valid, dut_a.sb_q[2].wb_en,
                dut_a.sb_q[2].mem_r_en, dut_a.sb_q[2].dest), 1'b0);
            chk("ld_early_b2", clash(dut_b.sb_q[1].valid, dut_b.sb_q[1].src1, dut_b.sb_q[1].src1_vld,
                dut_b.sb_q[1].src2, dut_b.sb_q[1].src2_vld, dut_b.sb_q[2].valid, dut_b.sb_q[2].wb_en,
                dut_b.sb_q[2].mem_r_en, dut_b.sb_q[2].dest), 1'b0);
            chk("ld_early_b3", clash(dut_b.sb_q[1].valid, dut_b.sb_q[1].src1, dut_b.sb_q[1].src1_vld,
                dut_b.sb_q[1].src2, dut_b.sb_q[1].src2_vld, dut_b.sb_q[3].valid, dut_b.sb_q[3].wb_en,
                dut_b.sb_q[3].mem_r_en, dut_b.sb_q[3].dest), 1'b0);
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; fwd_en = 1'b1; hold = 1'b0; flush = 1'b0;
        id_valid = 1'b0; id_src1 = '0; id_src2 = '0; id_src1_vld = 1'b0; id_src2_vld = 1'b0;
        id_dest = '0; id_wb_en = 1'b0; id_mem_r_en = 1'b0;
        exe_rn = 32'h1234_0001;
        exe_rm = 32'h1234_0002;
        stage_res_a = {32'hDEAD_BEEF, 32'h0000_0005};
        stage_res_b = {32'h4444_4444, 32'hCAFE_F00D, 32'h2222_2222, 32'h1111_1111};
        #1;
        chk("rst_hz", hazard_a, 0);
        chk("rst_sel1", sel1_a, 0);
        chk("rst_sel2", sel2_a, 0);
        chk("rst_op1", op1_a, 32'h1234_0001);
        chk("rst_op2", op2_a, 32'h1234_0002);
        chk("rst_ev", exe_valid_a, 0);
        #1 rst = 1'b1;

        // ADD R1 then SUB R2,R1,R3: ALU result forwarded from stage 2
        dec(4'd2, 1'b1, 4'd3, 1'b1, 4'd1, 1'b1, 1'b0);
        #1 chk("add_hz", hazard_a, 0);
        tick();
        dec(4'd1, 1'b1, 4'd3, 1'b1, 4'd2, 1'b1, 1'b0);
        #1 chk("sub_hz", hazard_a, 0);
        chk("sub_ev", exe_valid_a, 1);
        tick();
        id_valid = 1'b0;
        #1;
        chk("sub_sel1", sel1_a, 1);
        chk("sub_op1", op1_a, 32'h0000_0005);
        chk("sub_sel2", sel2_a, 0);
        chk("sub_op2", op2_a, 32'h1234_0002);

        // LDR R4 then ADD R5,R4,R4: one bubble, then load data from stage 3
        idle(3);
        dec(4'd0, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 1'b1);
        #1 chk("ldr_hz", hazard_a, 0);
        tick();
        dec(4'd4, 1'b0, 4'd4, 1'b0, 4'd9, 1'b1, 1'b0);
        #1 chk("nouse_hz", hazard_a, 0);
        dec(4'd4, 1'b1, 4'd4, 1'b1, 4'd5, 1'b1, 1'b0);
        #1 chk("ld_hz1", hazard_a, 1);
        tick();
        chk("ld_hz2", hazard_a, 0);
        chk("ld_bubble", exe_valid_a, 0);
        tick();
        id_valid = 1'b0;
        #1;
        chk("ld_sel1", sel1_a, 2);
        chk("ld_sel2", sel2_a, 2);
        chk("ld_op1", op1_a, 32'hDEAD_BEEF);
        chk("ld_op2", op2_a, 32'hDEAD_BEEF);

        // R6 written in stages 2 and 3: youngest wins
        idle(3);
        stage_res_a = {32'h2222_2222, 32'h1111_1111};
        dec(4'd0, 1'b0, 4'd0, 1'b0, 4'd6, 1'b1, 1'b0);
        tick();
        tick();
        dec(4'd6, 1'b1, 4'd0, 1'b0, 4'd7, 1'b1, 1'b0);
        #1 chk("dup_hz", hazard_a, 0);
        tick();
        id_valid = 1'b0;
        #1;
        chk("dup_sel1", sel1_a, 1);
        chk("dup_op1", op1_a, 32'h1111_1111);
        fwd_en = 1'b0;
        #1;
        chk("nofwd_sel1", sel1_a, 0);
        chk("nofwd_op1", op1_a, 32'h1234_0001);

        // Same sequence in stall-only mode: two stall cycles
        idle(3);
        dec(4'd0, 1'b0, 4'd0, 1'b0, 4'd6, 1'b1, 1'b0);
        tick();
        tick();
        dec(4'd6, 1'b1, 4'd0, 1'b0, 4'd7, 1'b1, 1'b0);
        #1 chk("so_hz1", hazard_a, 1);
        tick();
        chk("so_hz2", hazard_a, 1);
        chk("so_sel_a", sel1_a, 0);
        tick();
        chk("so_hz3", hazard_a, 0);
        tick();
        id_valid = 1'b0;
        #1;
        chk("so_ev", exe_valid_a, 1);
        chk("so_sel_b", sel1_a, 0);

        // hold with a load in EXE; flush during hold must not squash anything
        fwd_en = 1'b1;
        idle(3);
        dec(4'd0, 1'b1, 4'd0, 1'b0, 4'd7, 1'b1, 1'b1);
        tick();
        dec(4'd7, 1'b1, 4'd0, 1'b0, 4'd8, 1'b1, 1'b0);
        #1 chk("hold_hz0", hazard_a, 1);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            flush = (i == 1);
            tick();
            chk("hold_hz", hazard_a, 1);
            chk("hold_ev", exe_valid_a, 1);
        end
        flush = 1'b0;
        hold  = 1'b0;
        tick();
        chk("rel_hz", hazard_a, 0);
        chk("rel_ev", exe_valid_a, 0);
        tick();
        chk("rel_ev2", exe_valid_a, 1);
        chk("rel_sel1", sel1_a, 2);
        chk("rel_op1", op1_a, 32'h2222_2222);

        // Asynchronous reset between edges with live entries
        dec(4'd8, 1'b1, 4'd0, 1'b0, 4'd9, 1'b1, 1'b0);
        fwd_en = 1'b0;
        #1 chk("pre_rst_hz", hazard_a, 1);
        fwd_en = 1'b1;
        rst = 1'b0;
        #0.5;
        chk("mid_rst_sel1", sel1_a, 0);
        chk("mid_rst_sel2", sel2_a, 0);
        chk("mid_rst_ev", exe_valid_a, 0);
        chk("mid_rst_op1", op1_a, 32'h1234_0001);
        fwd_en = 1'b0;
        #0.5;
        chk("mid_rst_hz", hazard_a, 0);
        rst = 1'b1;
        fwd_en = 1'b1;

        // flush squashes the decode instruction
        dec(4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        id_valid = 1'b0;
        #1 chk("flush_ev", exe_valid_a, 0);

        // 5-stage instance, load data from stage 4: two stall cycles
        idle(5);
        dec(4'd0, 1'b1, 4'd0, 1'b0, 4'd2, 1'b1, 1'b1);
        #1 chk("b_ldr_hz", hazard_b, 0);
        tick();
        dec(4'd2, 1'b1, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0);
        #1 chk("b_hz1", hazard_b, 1);
        tick();
        chk("b_hz2", hazard_b, 1);
        tick();
        chk("b_hz3", hazard_b, 0);
        tick();
        id_valid = 1'b0;
        #1;
        chk("b_ev", exe_valid_b, 1);
        chk("b_sel1", sel1_b, 3);
        chk("b_op1", op1_b, 32'hCAFE_F00D);
        chk("b_sel2", sel2_b, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Parametrised successor to the fixed EXE/MEM/WB hazard-detection and forwarding logic.
- Tracks every in-flight instruction after decode in an internal scoreboard pipeline of STAGES entries, where stage 1 is EXE and stage STAGES is WB.
- Produces the decode stall, the per-operand forwarding selects and the forwarded operand values for EXE.
- Load latency and the forwarding enable are configurable.

Parameters:
- RA_W, 4, register-address width.
- DATA_W, 32, operand/result width.
- STAGES, 3, tracked post-decode stages; legal range 2..8.
- LOAD_STAGE, 3, first stage whose result bus carries load data; legal range 2..STAGES.
- SEL_W, $clog2(STAGES), forwarding-select width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- fwd_en  in  1  1 = forwarding mode, 0 = stall-only mode.
- hold  in  1  global pipeline freeze (memory wait).
- flush  in  1  squash the decode-stage instruction (branch taken in EXE).
- id_valid  in  1  decode slot holds a real instruction.
- id_src1, id_src2  in  RA_W  each  decode source registers.
- id_src1_vld, id_src2_vld  in  1  each  source is actually read.
- id_dest  in  RA_W  decode destination register.
- id_wb_en  in  1  decode instruction writes back.
- id_mem_r_en  in  1  decode instruction is a load.
- exe_rn, exe_rm  in  DATA_W  each  register-file values registered for EXE.
- stage_res  in  (STAGES-1)*DATA_W  write-back value of stage k in slice k-2, for k = 2..STAGES.
- hazard  out  1  stall decode/fetch this cycle.
- sel1, sel2  out  SEL_W  each  0 = register file, j = forward from stage j+1.
- op1, op2  out  DATA_W  each  forwarded EXE operands.
- exe_valid  out  1  stage 1 holds a real instruction.

Behaviour:
- Each scoreboard entry holds: valid, wb_en, mem_r_en, dest, src1, src1_vld, src2, src2_vld.
- Reset (rst low, asynchronous): all entries cleared to invalid.
  - Consequently hazard=0, sel1=sel2=0, op1=exe_rn, op2=exe_rm, exe_valid=0.
- Advance on a rising clk when hold=0:
  - Entry k+1 takes entry k, for k = 1..STAGES-1; the entry leaving stage STAGES is dropped.
  - Entry 1 takes the decode fields when id_valid & !hazard & !flush; otherwise entry 1 becomes a bubble (valid=0).
- hold=1: all entries keep their value. flush is ignored while hold=1, so the source must hold flush asserted until a non-held edge.
- Match(s, k) = entry k valid & entry k wb_en & entry k dest == s.
- hazard (combinational) = id_valid & OR over the used decode sources s of:
  - fwd_en=0: Match(s, k) for any k in 1..STAGES-1. Stage STAGES is never a hazard because the register file writes first.
  - fwd_en=1: Match(s, k) & entry k mem_r_en, for any k in 1..LOAD_STAGE-2 (load data not yet available in time).
- hazard is still computed during hold and is independent of flush.
- Forwarding (combinational, applies to stage-1 sources):
  - sel = j-1, where j is the smallest k in 2..STAGES with Match(src, k) and the corresponding src_vld set. The youngest producer wins.
  - sel = 0 if there is no match, fwd_en=0, or entry 1 is invalid.
  - op = sel==0 ? exe_rn/exe_rm : slice sel-1 of stage_res.
- A matching load in stage k < LOAD_STAGE cannot occur at EXE, because the hazard logic prevents it. The bench asserts this never happens.
- Register 15 is not special-cased.

Test Plan:
- Reset mid-run with entries valid: rst low for 1 ns between edges -> hazard=0, sel1=sel2=0, exe_valid=0 immediately.
- fwd_en=1, ADD R1 then SUB R2,R1,R3 back-to-back -> no hazard; next cycle sel1=1, op1=stage_res[31:0]=0x0000_0005, sel2=0.
- fwd_en=1, LDR R4 then ADD R5,R4,R4 -> hazard=1 for exactly 1 cycle with a bubble inserted; then sel1=sel2=2, op=slice 1 (load data 0xDEAD_BEEF).
- Same producer dest R6 in stages 2 and 3 -> sel=1 (younger wins). fwd_en=0 with the same sequence -> hazard=1 for 2 cycles, sel always 0.
- hold=1 for 3 cycles with a load in stage 1 -> entries frozen, hazard stays 1; flush pulsed during hold is ignored; after release the pipeline advances by one stage per clock.
- Parameters STAGES=5, LOAD_STAGE=4: LDR R2 followed by a consumer -> hazard for 2 cycles, then sel=3 selects stage_res slice 2.
